// File: rtl/shift_pipe_pkg.sv
// Shared shifter definitions: operation encodings and the operation-width constant.
// Used by the shift pipeline and the ALU decoder.
package shifter_defs;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ROL = 3'b000,
        OP_SLL = 3'b001,
        OP_ROR = 3'b010,
        OP_SRL = 3'b011,
        OP_SRA = 3'b100
    } shift_op_e;

    // Encodings 101..111 are reserved and travel through the pipe untouched.
    function automatic logic opIsLegal(input logic [OP_W-1:0] op);
        return (op <= 3'b100);
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One combinational level of the barrel shifter: shift or rotate by the fixed amount SHAMT.
// Illegal ops and a disabled stage pass the data through unchanged.
module shift_stage
    import shifter_defs::*;
#(
    parameter int WIDTH = 16,
    parameter int SHAMT = 1
) (
    input  logic             i_en,
    input  logic [OP_W-1:0]  i_op,
    input  logic             i_fill,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    // Ones in the SHAMT vacated MSB positions, used for the arithmetic fill.
    localparam logic [WIDTH-1:0] HIGH_MASK = ~({WIDTH{1'b1}} >> SHAMT);

    always_comb begin
        o_data = i_data;
        if (i_en) begin
            case (i_op)
                OP_ROL:  o_data = (i_data << SHAMT) | (i_data >> (WIDTH - SHAMT));
                OP_SLL:  o_data = i_data << SHAMT;
                OP_ROR:  o_data = (i_data >> SHAMT) | (i_data << (WIDTH - SHAMT));
                OP_SRL:  o_data = i_data >> SHAMT;
                OP_SRA:  o_data = (i_data >> SHAMT) | (i_fill ? HIGH_MASK : '0);
                default: o_data = i_data;
            endcase
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter with valid/ready flow control; stage k applies count bit k.
// Holds the per-stage registers and the combinational ready chain.
module shift_pipe
    import shifter_defs::*;
#(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_cnt,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err
);

    logic [CNT_W-1:0] r_valid;
    logic [WIDTH-1:0] r_data [CNT_W];
    logic [OP_W-1:0]  r_op   [CNT_W];
    logic [CNT_W-1:0] r_cnt  [CNT_W];
    logic             r_sign [CNT_W];

    logic [CNT_W-1:0] w_adv;
    logic [CNT_W-1:0] w_load;
    logic [CNT_W-1:0] w_stgValid;
    logic [WIDTH-1:0] w_stgData [CNT_W];
    logic [OP_W-1:0]  w_stgOp   [CNT_W];
    logic [CNT_W-1:0] w_stgCnt  [CNT_W];
    logic             w_stgFill [CNT_W];
    logic [WIDTH-1:0] w_shifted [CNT_W];

    // A stage may take new content when it is empty or its content is leaving,
    // which lets bubbles collapse behind a stalled output.
    always_comb begin
        w_adv = '0;
        w_load = '0;
        w_adv[CNT_W-1] = out_ready;
        for (int k = CNT_W - 2; k >= 0; k--) begin
            w_adv[k] = !r_valid[k+1] || w_adv[k+1];
        end
        for (int k = 0; k < CNT_W; k++) begin
            w_load[k] = !r_valid[k] || w_adv[k];
        end
    end

    for (genvar k = 0; k < CNT_W; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_stgValid[k] = in_valid;
            assign w_stgData[k]  = in_data;
            assign w_stgOp[k]    = in_op;
            assign w_stgCnt[k]   = in_cnt;
            assign w_stgFill[k]  = in_data[WIDTH-1];
        end else begin : g_body
            assign w_stgValid[k] = r_valid[k-1];
            assign w_stgData[k]  = r_data[k-1];
            assign w_stgOp[k]    = r_op[k-1];
            assign w_stgCnt[k]   = r_cnt[k-1];
            assign w_stgFill[k]  = r_sign[k-1];
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .SHAMT (1 << k)
        ) u_shift (
            .i_en   (w_stgCnt[k][k]),
            .i_op   (w_stgOp[k]),
            .i_fill (w_stgFill[k]),
            .i_data (w_stgData[k]),
            .o_data (w_shifted[k])
        );
    end

    // Payload only moves with a valid op, so a held result never changes under a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int k = 0; k < CNT_W; k++) begin
                r_data[k] <= '0;
                r_op[k]   <= '0;
                r_cnt[k]  <= '0;
                r_sign[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < CNT_W; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= w_stgValid[k];
                    if (w_stgValid[k]) begin
                        r_data[k] <= w_shifted[k];
                        r_op[k]   <= w_stgOp[k];
                        r_cnt[k]  <= w_stgCnt[k];
                        r_sign[k] <= w_stgFill[k];
                    end
                end
            end
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_valid[CNT_W-1];
    assign out_data  = r_data[CNT_W-1];
    assign out_err   = !opIsLegal(r_op[CNT_W-1]);

endmodule

// File: tb/tb_shift_pipe.sv
// Randomised and directed bench for shift_pipe at WIDTH=16 against a scoreboard model.
module tb_shift_pipe;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [CNT_W-1:0] in_cnt = '0;
    logic [2:0]       in_op = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;
    logic             out_err;

    int vectorCount = 0;
    int miscompareCount = 0;
    int cycleCount = 0;

    logic [WIDTH:0] expQ [$];
    int             emitCycles [$];
    logic           stallPrev = 1'b0;
    logic [WIDTH-1:0] prevData = '0;
    logic           prevErr = 1'b0;

    shift_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cnt    (in_cnt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // Reference: {err, result} straight from the mode definitions.
    function automatic logic [WIDTH:0] refModel(input logic [WIDTH-1:0] d, input int c,
                                                input logic [2:0] op);
        int unsigned x;
        int unsigned r;
        logic signed [WIDTH-1:0] s;
        x = 32'(d);
        s = d;
        case (op)
            3'b000:  r = (x << c) | (x >> (WIDTH - c));
            3'b001:  r = x << c;
            3'b010:  r = (x >> c) | (x << (WIDTH - c));
            3'b011:  r = x >> c;
            3'b100:  r = 32'(unsigned'(s >>> c));
            default: return {1'b1, d};
        endcase
        return {1'b0, r[WIDTH-1:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompareCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Scoreboard: records accepted ops, checks every emitted result and stall stability.
    always @(negedge clk) begin
        cycleCount++;
        if (!rst_n) begin
            expQ.delete();
            stallPrev = 1'b0;
        end else begin
            if (stallPrev) begin
                checkOutput("stallValid", 32'(out_valid), 32'(1));
                checkOutput("stallData", 32'(out_data), 32'(prevData));
                checkOutput("stallErr", 32'(out_err), 32'(prevErr));
            end
            if (out_valid && out_ready) begin
                emitCycles.push_back(cycleCount);
                if (expQ.size() == 0) begin
                    checkOutput("spuriousOut", 32'(out_valid), 32'(0));
                end else begin
                    logic [WIDTH:0] exp;
                    exp = expQ.pop_front();
                    checkOutput("outData", 32'(out_data), 32'(exp[WIDTH-1:0]));
                    checkOutput("outErr", 32'(out_err), 32'(exp[WIDTH]));
                end
            end
            if (in_valid && in_ready) begin
                expQ.push_back(refModel(in_data, int'(in_cnt), in_op));
            end
            stallPrev = out_valid && !out_ready;
            prevData = out_data;
            prevErr = out_err;
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] c,
                                 input logic [2:0] op, output int waits);
        int w;
        in_valid = 1'b1;
        in_data = d;
        in_cnt = c;
        in_op = op;
        for (w = 0; w < 100; w++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (w == 100) checkOutput("acceptTimeout", 32'(w), 32'(0));
        waits = w;
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input string tag);
        for (int i = 0; i < 200 && expQ.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput(tag, 32'(expQ.size()), 32'(0));
    endtask

    initial begin
        int waits;
        int cycles;
        int accepted;
        logic pending;

        $display("[TB] start");
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstOutValid", 32'(out_valid), 32'(0));
        checkOutput("rstOutData", 32'(out_data), 32'(0));
        checkOutput("rstOutErr", 32'(out_err), 32'(0));
        checkOutput("rstInReady", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency of a single unstalled op
        applyStimulus(16'h0001, 4'd15, 3'b001, waits);
        in_valid = 1'b0;
        cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cycles++;
            if (out_valid) break;
        end
        checkOutput("latency", 32'(cycles), 32'(CNT_W));
        checkOutput("sllData", 32'(out_data), 32'h8000);
        @(posedge clk);
        #1;

        // Directed mode examples
        applyStimulus(16'h8000, 4'd3, 3'b100, waits);
        applyStimulus(16'h8000, 4'd3, 3'b011, waits);
        applyStimulus(16'h0001, 4'd1, 3'b010, waits);
        applyStimulus(16'hA005, 4'd4, 3'b000, waits);
        applyStimulus(16'h1234, 4'd5, 3'b110, waits);
        applyStimulus(16'h1234, 4'd0, 3'b001, waits);
        in_valid = 1'b0;
        waitDrain("drainDirected");

        // Back-to-back ops with an always-ready sink
        emitCycles.delete();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(16'($urandom), 4'($urandom), 3'($urandom_range(0, 4)), waits);
            checkOutput("b2bInReady", 32'(waits), 32'(0));
        end
        in_valid = 1'b0;
        waitDrain("drainB2b");
        checkOutput("b2bCount", 32'(emitCycles.size()), 32'(8));
        for (int i = 1; i < emitCycles.size(); i++) begin
            checkOutput("b2bSpacing", 32'(emitCycles[i] - emitCycles[0]), 32'(i));
        end

        // Fill against a stalled sink, then release
        out_ready = 1'b0;
        accepted = 0;
        in_valid = 1'b1;
        in_data = 16'($urandom);
        in_cnt = 4'($urandom);
        in_op = 3'($urandom_range(0, 4));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted++;
                @(posedge clk);
                #1;
                in_data = 16'($urandom);
                in_cnt = 4'($urandom);
                in_op = 3'($urandom_range(0, 4));
            end else begin
                @(posedge clk);
                #1;
            end
        end
        checkOutput("fullAccepts", 32'(accepted), 32'(CNT_W));
        checkOutput("fullInReady", 32'(in_ready), 32'(0));
        checkOutput("fullOutValid", 32'(out_valid), 32'(1));
        in_valid = 1'b0;
        emitCycles.delete();
        out_ready = 1'b1;
        waitDrain("drainStall");
        checkOutput("stallEmits", 32'(emitCycles.size()), 32'(CNT_W));

        // Reset with ops in flight
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'($urandom), 4'($urandom), 3'($urandom_range(0, 4)), waits);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("midRstOutValid", 32'(out_valid), 32'(0));
        checkOutput("midRstInReady", 32'(in_ready), 32'(1));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("postRstQuiet", 32'(out_valid), 32'(0));
        end
        @(posedge clk);
        #1;

        // Random traffic with random backpressure
        accepted = 0;
        pending = 1'b0;
        for (int cyc = 0; cyc < 6000 && accepted < 300; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!pending) begin
                if ($urandom_range(0, 4) != 0) begin
                    in_valid = 1'b1;
                    in_data = 16'($urandom);
                    in_cnt = 4'($urandom);
                    in_op = 3'($urandom_range(0, 7));
                    pending = 1'b1;
                end else begin
                    in_valid = 1'b0;
                    in_data = 16'($urandom);
                end
            end
            @(negedge clk);
            if (pending && in_ready) begin
                accepted++;
                pending = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("randomAccepted", 32'(accepted), 32'(300));
        in_valid = 1'b0;
        out_ready = 1'b1;
        waitDrain("drainRandom");

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
